// File: rtl/div_clock_ctrl_pkg.sv
// Shared types for the divided-clock controller.
//   _pwm_onoff     : generator enable encoding (PWM_OFF / PWM_ON)
//   _divctrl_state : controller FSM states
// Also provides a default for `DIVCLK_WIDTH when the build does not set one.
`ifndef DIVCLK_WIDTH
`define DIVCLK_WIDTH 8
`endif

package div_clock_ctrl_pkg;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [1:0] {
    DC_OFF,
    DC_RUN,
    DC_PEND,
    DC_RAMP
  } _divctrl_state;

endpackage

// File: rtl/div_clock_ctrl_if.sv
// Request channel into the divided-clock controller.
//   req_valid   : request present (master -> slave)
//   req_ready   : request can be accepted (slave -> master)
//   req_divider : requested divider value
//   req_onoff   : requested PWM_ON / PWM_OFF
interface div_clock_ctrl_if
  import div_clock_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = `DIVCLK_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [DIV_W-1:0] req_divider;
  _pwm_onoff        req_onoff;

  modport master (
    output req_valid,
    output req_divider,
    output req_onoff,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_divider,
    input  req_onoff,
    output req_ready
  );

endinterface

// File: rtl/div_edge_det.sv
// Registered falling-edge detector for the fed-back divided clock.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   div_clk  : divided clock from the generator (clk domain)
//   boundary : high for the one cycle after div_clk falls
module div_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic div_clk,
  output logic boundary
);

  logic div_clk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_clk_q <= 1'b0;
    end else begin
      div_clk_q <= div_clk;
    end
  end

  assign boundary = div_clk_q & ~div_clk;

endmodule

// File: rtl/div_clock_ctrl.sv
// Run-time controller for the PWM divided-clock generator.
// Divider changes and stops from RUN are deferred to the next div_clk period
// boundary so the generator never emits a runt or stretched period.
// force_off stops the generator at the next edge regardless of alignment.
// Optional soft start: define DIVCTRL_SOFTSTART_EN to start OFF->ON at a
// divider RAMP_SPAN above target and walk down RAMP_STEP per boundary.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   req_bus     : request channel (slave modport)
//   force_off   : fault trip, immediate stop
//   div_clk     : divided clock fed back from the generator
//   div_out     : divider driven to the generator
//   pwm_onoff   : enable driven to the generator
//   upd_done    : one-cycle pulse when a request takes effect
//   busy        : a request (or ramp) is waiting on a boundary
module div_clock_ctrl
  import div_clock_ctrl_pkg::*;
#(
  parameter int unsigned      DIV_W     = `DIVCLK_WIDTH,
  parameter logic [DIV_W-1:0] DIV_RESET = '0,
  parameter int unsigned      RAMP_SPAN = 8,
  parameter int unsigned      RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  div_clock_ctrl_if.slave   req_bus,
  input  logic              force_off,
  input  logic              div_clk,
  output logic [DIV_W-1:0]  div_out,
  output _pwm_onoff         pwm_onoff,
  output logic              upd_done,
  output logic              busy
);

  _divctrl_state    state;
  logic [DIV_W-1:0] shadow_div;   // pending divider, or ramp target in DC_RAMP
  _pwm_onoff        shadow_onoff;
  logic             boundary;
  logic             accept;

  div_edge_det u_edge_det (
    .clk      (clk),
    .reset    (reset),
    .div_clk  (div_clk),
    .boundary (boundary)
  );

  assign req_bus.req_ready = !reset && (state != DC_PEND) && (state != DC_RAMP) && !force_off;
  assign accept            = req_bus.req_valid && req_bus.req_ready;
  assign busy              = (state == DC_PEND) || (state == DC_RAMP);

`ifdef DIVCTRL_SOFTSTART_EN
  localparam logic [DIV_W:0]   SpanExt = (DIV_W + 1)'(RAMP_SPAN);
  localparam logic [DIV_W-1:0] StepW   = DIV_W'(RAMP_STEP);

  logic [DIV_W:0]   ramp_sum;
  logic [DIV_W-1:0] ramp_start;
  logic [DIV_W-1:0] ramp_next;

  always_comb begin
    // Extra carry bit so the start point saturates instead of wrapping.
    ramp_sum   = {1'b0, req_bus.req_divider} + SpanExt;
    ramp_start = ramp_sum[DIV_W] ? '1 : ramp_sum[DIV_W-1:0];
    // div_out never drops below the target, so the difference cannot underflow.
    ramp_next  = ((div_out - shadow_div) > StepW) ? (div_out - StepW) : shadow_div;
  end
`else
  logic unused_ramp;
  assign unused_ramp = ^{RAMP_SPAN, RAMP_STEP};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DC_OFF;
      div_out      <= DIV_RESET;
      pwm_onoff    <= PWM_OFF;
      upd_done     <= 1'b0;
      shadow_div   <= '0;
      shadow_onoff <= PWM_OFF;
    end else if (force_off) begin
      // Fault path: stop now, drop anything pending, keep the divider.
      state        <= DC_OFF;
      pwm_onoff    <= PWM_OFF;
      upd_done     <= 1'b0;
      shadow_div   <= '0;
      shadow_onoff <= PWM_OFF;
    end else begin
      upd_done <= 1'b0;
      unique case (state)
        DC_OFF: begin
          if (accept) begin
            if (req_bus.req_onoff == PWM_ON) begin
              pwm_onoff <= PWM_ON;
`ifdef DIVCTRL_SOFTSTART_EN
              div_out    <= ramp_start;
              shadow_div <= req_bus.req_divider;
              state      <= DC_RAMP;
`else
              div_out    <= req_bus.req_divider;
              upd_done   <= 1'b1;
              state      <= DC_RUN;
`endif
            end else begin
              upd_done <= 1'b1;
            end
          end
        end
        DC_RUN: begin
          if (accept) begin
            shadow_div   <= req_bus.req_divider;
            shadow_onoff <= req_bus.req_onoff;
            state        <= DC_PEND;
          end
        end
        DC_PEND: begin
          if (boundary) begin
            upd_done <= 1'b1;
            if (shadow_onoff == PWM_OFF) begin
              pwm_onoff <= PWM_OFF;
              state     <= DC_OFF;
            end else begin
              div_out <= shadow_div;
              state   <= DC_RUN;
            end
          end
        end
        DC_RAMP: begin
`ifdef DIVCTRL_SOFTSTART_EN
          if (boundary) begin
            div_out <= ramp_next;
            if (ramp_next == shadow_div) begin
              upd_done <= 1'b1;
              state    <= DC_RUN;
            end
          end
`else
          state <= DC_OFF;
`endif
        end
        default: state <= DC_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_div_clock_ctrl.sv
module tb_div_clock_ctrl;
  import div_clock_ctrl_pkg::*;

  localparam int unsigned DW      = 8;
  localparam int          ALL_ONE = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          force_off;
  logic          div_clk;
  logic [DW-1:0] div_out;
  _pwm_onoff     pwm_onoff;
  logic          upd_done;
  logic          busy;

  div_clock_ctrl_if #(.DIV_W(DW)) bus ();

  div_clock_ctrl #(
    .DIV_W     (DW),
    .DIV_RESET (8'h00),
    .RAMP_SPAN (8),
    .RAMP_STEP (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_bus   (bus.slave),
    .force_off (force_off),
    .div_clk   (div_clk),
    .div_out   (div_out),
    .pwm_onoff (pwm_onoff),
    .upd_done  (upd_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Divided-clock generator: each phase lasts div_out+1 clk cycles, held low while off.
  logic [DW-1:0] gen_cnt;
  always @(posedge clk) begin
    if (reset || pwm_onoff == PWM_OFF) begin
      gen_cnt <= '0;
      div_clk <= 1'b0;
    end else if (gen_cnt >= div_out) begin
      gen_cnt <= '0;
      div_clk <= ~div_clk;
    end else begin
      gen_cnt <= gen_cnt + 1'b1;
    end
  end

  // Phase-length monitor (lengths in clk cycles, only while running).
  int   phases[$];
  int   run_len = 1;
  logic dc_prev = 1'b0;
  always @(negedge clk) begin
    if (pwm_onoff != PWM_ON) begin
      run_len <= 1;
      dc_prev <= div_clk;
    end else if (div_clk != dc_prev) begin
      phases.push_back(run_len);
      run_len <= 1;
      dc_prev <= div_clk;
    end else begin
      run_len <= run_len + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: settings the generator should currently be driven with.
  bit mdl_on  = 1'b0;
  int mdl_div = 0;

  // Issue one request at a negedge and follow it until it takes effect.
  // A request from RUN lands one cycle after the first observed div_clk fall.
  task automatic req_and_check(input bit on, input int div, input bit do_force, input int force_at);
    logic prev, cur;
    bit   done;
    int   ramp_exp;
    bus.req_valid   = 1'b1;
    bus.req_divider = DW'(div);
    bus.req_onoff   = on ? PWM_ON : PWM_OFF;
    #1;
    check("ready_idle", bus.req_ready, 1);
    prev = div_clk;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!mdl_on) begin
`ifdef DIVCTRL_SOFTSTART_EN
      if (on) begin
        ramp_exp = (div + 8 > ALL_ONE) ? ALL_ONE : div + 8;
        check("ramp_start", div_out, ramp_exp);
        check("ramp_pwm", pwm_onoff, PWM_ON);
        check("ramp_noupd0", upd_done, 0);
        check("ramp_busy0", busy, 1);
        mdl_on = 1'b1;
        done   = 1'b0;
        for (int k = 0; k < 1200 && !done; k++) begin
          cur = div_clk;
          @(negedge clk);
          if (prev && !cur) begin
            ramp_exp = (ramp_exp - div > 1) ? ramp_exp - 1 : div;
            done     = (ramp_exp == div);
            check("ramp_step", div_out, ramp_exp);
            check("ramp_upd", upd_done, done);
            check("ramp_busy", busy, !done);
          end else begin
            check("ramp_hold", div_out, ramp_exp);
            check("ramp_noupd", upd_done, 0);
          end
          prev = cur;
        end
        check("ramp_final", div_out, div);
        mdl_div = div;
        @(negedge clk);
        check("pulse_end", upd_done, 0);
        return;
      end
`endif
      check("off_upd", upd_done, 1);
      check("off_busy", busy, 0);
      if (on) begin
        mdl_on  = 1'b1;
        mdl_div = div;
      end
      check("off_pwm", pwm_onoff, mdl_on);
      check("off_div", div_out, mdl_div);
      @(negedge clk);
      check("pulse_end", upd_done, 0);
      return;
    end
    check("pend_busy", busy, 1);
    check("pend_ready", bus.req_ready, 0);
    for (int k = 0; k < 1200; k++) begin
      cur = div_clk;
      if (do_force && k == force_at) begin
        force_off = 1'b1;
        @(negedge clk);
        force_off = 1'b0;
        check("force_pwm", pwm_onoff, PWM_OFF);
        check("force_div", div_out, mdl_div);
        check("force_noupd", upd_done, 0);
        check("force_busy", busy, 0);
        mdl_on = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("force_quiet_upd", upd_done, 0);
          check("force_quiet_pwm", pwm_onoff, PWM_OFF);
        end
        return;
      end
      @(negedge clk);
      if (prev && !cur) begin
        check("apply_upd", upd_done, 1);
        check("apply_busy", busy, 0);
        if (on) mdl_div = div;
        else    mdl_on  = 1'b0;
        check("apply_pwm", pwm_onoff, mdl_on);
        check("apply_div", div_out, mdl_div);
        @(negedge clk);
        check("pulse_end", upd_done, 0);
        check("ready_after", bus.req_ready, 1);
        return;
      end
      check("pend_hold_div", div_out, mdl_div);
      check("pend_hold_pwm", pwm_onoff, PWM_ON);
      check("pend_hold_upd", upd_done, 0);
      check("pend_hold_ready", bus.req_ready, 0);
      prev = cur;
    end
    n_errors++;
    $display("FAIL pend_timeout: got no div_clk fall, expected one within 1200 cycles");
  endtask

  typedef struct {
    bit on;
    int div;
    bit frc;
    int frc_at;
    bit exp_on;
    int exp_div;
    bit chk_phase;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pmin, pmax;
    vecs[0]  = '{1, 4,   0, 0, 1, 4,   0};
    vecs[1]  = '{1, 9,   0, 0, 1, 9,   1};
    vecs[2]  = '{1, 9,   0, 0, 1, 9,   0};
    vecs[3]  = '{1, 0,   0, 0, 1, 0,   0};
    vecs[4]  = '{1, 3,   0, 0, 1, 3,   0};
    vecs[5]  = '{0, 3,   0, 0, 0, 3,   0};
    vecs[6]  = '{0, 7,   0, 0, 0, 3,   0};
    vecs[7]  = '{1, 5,   0, 0, 1, 5,   0};
    vecs[8]  = '{1, 2,   1, 2, 0, 5,   0};
    vecs[9]  = '{1, 6,   0, 0, 1, 6,   0};
    vecs[10] = '{0, 0,   0, 0, 0, 6,   0};
    vecs[11] = '{1, 255, 0, 0, 1, 255, 0};
    vecs[12] = '{1, 1,   0, 0, 1, 1,   0};

    reset           = 1'b1;
    force_off       = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_divider = '0;
    bus.req_onoff   = PWM_OFF;
    repeat (3) @(negedge clk);
    check("rst_div", div_out, 0);
    check("rst_pwm", pwm_onoff, PWM_OFF);
    check("rst_upd", upd_done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.req_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", bus.req_ready, 1);
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].chk_phase) begin
        // Place the request in the middle of a high phase.
        for (int w = 0; w < 100 && !div_clk; w++) @(negedge clk);
        repeat (2) @(negedge clk);
        phases.delete();
      end
      req_and_check(vecs[i].on, vecs[i].div, vecs[i].frc, vecs[i].frc_at);
      check("vec_pwm", pwm_onoff, vecs[i].exp_on);
      check("vec_div", div_out, vecs[i].exp_div);
      if (vecs[i].chk_phase) begin
        repeat (25) @(negedge clk);
        pmin = 999;
        pmax = 0;
        foreach (phases[j]) begin
          if (phases[j] < pmin) pmin = phases[j];
          if (phases[j] > pmax) pmax = phases[j];
        end
        check("phase_min", pmin, 5);
        check("phase_max", pmax, 10);
      end
      if (!vecs[i].exp_on) begin
        repeat (15) @(negedge clk);
        check("off_divclk_low", div_clk, 0);
      end
    end

    // Reset while a request is pending.
    bus.req_valid   = 1'b1;
    bus.req_divider = DW'(2);
    bus.req_onoff   = PWM_ON;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rp_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rp_ready_in_reset", bus.req_ready, 0);
    @(negedge clk);
    check("rp_div", div_out, 0);
    check("rp_pwm", pwm_onoff, PWM_OFF);
    check("rp_upd", upd_done, 0);
    check("rp_busy_clr", busy, 0);
    reset = 1'b0;
    #1;
    check("rp_ready_after", bus.req_ready, 1);
    mdl_on  = 1'b0;
    mdl_div = 0;
    repeat (30) @(negedge clk);
    check("rp_no_late_upd_pwm", pwm_onoff, PWM_OFF);
    check("rp_no_late_upd_div", div_out, 0);

    // ON with divider 3 from OFF (ramps 11..3 when soft start is built in).
    req_and_check(1'b1, 3, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      req_and_check($urandom_range(0, 3) != 0, int'($urandom_range(0, 5)),
                    $urandom_range(0, 4) == 0, int'($urandom_range(0, 6)));
      check("rnd_pwm", pwm_onoff, mdl_on);
      check("rnd_div", div_out, mdl_div);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
